// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package seq_det_pkg;

  // Default longest pattern, in bits.
  localparam int MAX_LEN_DEFAULT = 8;

  // Widest mask the helper below can build; detector MAX_LEN must not exceed it.
  localparam int MASK_W = 32;

  // Bits needed to hold a pattern length in the range 0..max_len.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Mask with the low 'len' bits set; callers truncate it to their MAX_LEN.
  function automatic logic [MASK_W-1:0] pattern_mask(input int unsigned len);
    logic [MASK_W-1:0] m;
    for (int i = 0; i < MASK_W; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear first, otherwise increment unless already all ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial bit-pattern detector with registered match
// pulse and a saturating hit counter.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = MAX_LEN_DEFAULT,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               inp,
  input  logic               clr_count,
  output logic               outp,
  output logic [CNT_W-1:0]   hit_count,
  output logic               cfg_err
);

  // Configuration registers.
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic               enabled_q, enabled_d;
  logic               cfg_err_q, cfg_err_d;

  // History of accepted bits. Only the newest MAX_LEN-1 bits are stored:
  // together with the incoming bit they form the full MAX_LEN-bit window.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               outp_q, outp_d;

  logic [MAX_LEN-1:0] hist_shift;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_inc;
  logic               cfg_legal;
  logic               accept;
  logic               hit;
  logic               hit_pulse;

  assign hist_shift = {hist_q, inp};
  assign len_mask   = MAX_LEN'(pattern_mask(32'(len_q)));
  assign fill_inc   = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
  assign cfg_legal  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign accept     = in_valid && !cfg_load && enabled_q;
  assign hit        = (fill_inc == len_q) &&
                      (((hist_shift ^ pattern_q) & len_mask) == '0);
  assign hit_pulse  = accept && hit;

  // Next-state: a load resets history and wins over a same-edge input bit.
  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    enabled_d = enabled_q;
    cfg_err_d = cfg_err_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    outp_d    = 1'b0;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = cfg_len;
      overlap_d = cfg_overlap;
      enabled_d = cfg_legal;
      cfg_err_d = !cfg_legal;
      hist_d    = '0;
      fill_d    = '0;
    end else if (accept) begin
      hist_d = hist_shift[MAX_LEN-2:0];
      fill_d = (hit && !overlap_q) ? '0 : fill_inc;
      outp_d = hit;
    end
  end

  // State registers; reset leaves the detector unconfigured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      enabled_q <= 1'b0;
      cfg_err_q <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      outp_q    <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      enabled_q <= enabled_d;
      cfg_err_q <= cfg_err_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      outp_q    <= outp_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_hit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_count),
    .inc   (hit_pulse),
    .count (hit_count)
  );

  assign outp    = outp_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench: an 8-bit-counter detector and a 2-bit-counter detector
// share the same stimulus.
module tb_seq_pattern_detector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       in_valid;
  logic       inp;
  logic       clr_count;

  logic       outp;
  logic [7:0] hit_count;
  logic       cfg_err;
  logic       outp2;
  logic [1:0] hit_count2;
  logic       cfg_err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_pattern_detector #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .inp(inp),
    .clr_count(clr_count), .outp(outp), .hit_count(hit_count), .cfg_err(cfg_err)
  );

  seq_pattern_detector #(.MAX_LEN(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .inp(inp),
    .clr_count(clr_count), .outp(outp2), .hit_count(hit_count2), .cfg_err(cfg_err2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply a configuration load, optionally with a coincident input bit.
  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                      input logic iv, input logic b);
    @(negedge clk);
    cfg_load = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    in_valid = iv; inp = b; clr_count = 1'b0;
    @(posedge clk); #1;
    $display("load pattern=%b len=%0d overlap=%0d -> cfg_err=%0d outp=%0d",
             pat, len, ovl, cfg_err, outp);
  endtask

  // Send one qualified bit and check the match pulse that follows it.
  task automatic send(input logic b, input logic exp_o, input string tag);
    @(negedge clk);
    cfg_load = 1'b0; clr_count = 1'b0; in_valid = 1'b1; inp = b;
    @(posedge clk); #1;
    $display("bit %0d -> outp=%0d hit_count=%0d", b, outp, hit_count);
    check(tag, 32'(outp), 32'(exp_o));
  endtask

  // One cycle with in_valid low (inp driven high to tempt a false match).
  task automatic idle(input string tag);
    @(negedge clk);
    cfg_load = 1'b0; clr_count = 1'b0; in_valid = 1'b0; inp = 1'b1;
    @(posedge clk); #1;
    $display("idle -> outp=%0d", outp);
    check(tag, 32'(outp), 32'd0);
  endtask

  task automatic clear_count();
    @(negedge clk);
    cfg_load = 1'b0; in_valid = 1'b0; clr_count = 1'b1;
    @(posedge clk); #1;
    $display("clr_count -> hit_count=%0d", hit_count);
    check("clr_hit_count", 32'(hit_count), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; in_valid = 1'b0; inp = 1'b0; clr_count = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outp", 32'(outp), 32'd0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    rst_n = 1'b1;
    send(1'b1, 1'b0, "unconfigured_no_hit");

    // 1. Overlapping 101
    load(8'b101, 4'd3, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, "ovl_b1");
    send(1'b0, 1'b0, "ovl_b2");
    send(1'b1, 1'b1, "ovl_b3");
    send(1'b0, 1'b0, "ovl_b4");
    send(1'b1, 1'b1, "ovl_b5");
    check("ovl_hit_count", 32'(hit_count), 32'd2);
    idle("ovl_pulse_one_cycle");
    clear_count();

    // 2. Non-overlapping 101
    load(8'b101, 4'd3, 1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b0, "novl_b1");
    send(1'b0, 1'b0, "novl_b2");
    send(1'b1, 1'b1, "novl_b3");
    send(1'b0, 1'b0, "novl_b4");
    send(1'b1, 1'b0, "novl_b5");
    check("novl_hit_count", 32'(hit_count), 32'd1);

    // 3. Illegal configurations and load priority
    load(8'b101, 4'd0, 1'b1, 1'b0, 1'b0);
    check("len0_cfg_err", 32'(cfg_err), 32'd1);
    send(1'b1, 1'b0, "len0_b1");
    send(1'b0, 1'b0, "len0_b2");
    send(1'b1, 1'b0, "len0_b3");
    load(8'b101, 4'd9, 1'b1, 1'b0, 1'b0);
    check("len9_cfg_err", 32'(cfg_err), 32'd1);
    load(8'b101, 4'd3, 1'b1, 1'b0, 1'b0);
    check("legal_cfg_err", 32'(cfg_err), 32'd0);
    send(1'b1, 1'b0, "prio_b1");
    send(1'b0, 1'b0, "prio_b2");
    load(8'b101, 4'd3, 1'b1, 1'b1, 1'b1);
    check("prio_load_no_pulse", 32'(outp), 32'd0);
    send(1'b1, 1'b0, "prio_history_cleared");
    check("load_keeps_hit_count", 32'(hit_count), 32'd1);

    // 4. in_valid gaps
    load(8'b101, 4'd3, 1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b0, "gap_b1");
    idle("gap_idle1");
    idle("gap_idle2");
    idle("gap_idle3");
    send(1'b0, 1'b0, "gap_b2");
    send(1'b1, 1'b1, "gap_b3");
    check("gap_hit_count", 32'(hit_count), 32'd2);

    // 5. Reset mid-stream
    load(8'b101, 4'd3, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, "rstm_b1");
    send(1'b0, 1'b0, "rstm_b2");
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    $display("mid-stream reset -> outp=%0d hit_count=%0d cfg_err=%0d", outp, hit_count, cfg_err);
    check("rstm_outp", 32'(outp), 32'd0);
    check("rstm_hit_count", 32'(hit_count), 32'd0);
    check("rstm_cfg_err", 32'(cfg_err), 32'd0);
    send(1'b1, 1'b0, "rstm_unconfigured");

    // 6. Saturation and clear with L=1
    load(8'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b1, "sat_b1");
    send(1'b0, 1'b0, "sat_zero_no_hit");
    send(1'b1, 1'b1, "sat_b2");
    send(1'b1, 1'b1, "sat_b3");
    check("sat_count_at_3", 32'(hit_count2), 32'd3);
    send(1'b1, 1'b1, "sat_b4");
    send(1'b1, 1'b1, "sat_b5");
    check("sat_count_held", 32'(hit_count2), 32'd3);
    check("wide_count_5", 32'(hit_count), 32'd5);
    @(negedge clk);
    cfg_load = 1'b0; in_valid = 1'b1; inp = 1'b1; clr_count = 1'b1;
    @(posedge clk); #1;
    $display("bit 1 with clr_count -> outp=%0d hit_count=%0d sat_count=%0d",
             outp2, hit_count, hit_count2);
    check("clr_wins_sat_count", 32'(hit_count2), 32'd0);
    check("clr_wins_wide_count", 32'(hit_count), 32'd0);
    check("clr_outp_pulses", 32'(outp2), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; clr_count = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
